debounce_scan_ctrl: RTL and testbench



---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_scan_ctrl_scan_tick_gen.sv | 40 ++++
 rtl/debounce_scan_ctrl.sv | 113 +++++++++++
 tb/tb_debounce_scan_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared helpers for the debounce controller: width calculation and
// parameter legality checking used at elaboration time.
package debounce_pkg;

    // Number of bits needed to hold values 0..v-1, never less than 1.
    function automatic int clog2_min1(input int v);
        int w;
        w = 0;
        while ((1 << w) < v) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // True when the parameter set describes a buildable controller.
    function automatic bit params_ok(input int n_ch, input int tick_div, input int stable_ticks);
        return (n_ch >= 2) && (tick_div >= 1) && (stable_ticks >= 1);
    endfunction

endpackage

// File: rtl/debounce_scan_ctrl_scan_tick_gen.sv
// Prescaler that emits a one-cycle scan strobe every TICK_DIV enabled
// cycles. While en is low the count holds and no strobe is produced.
module scan_tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int PW = clog2_min1(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_reg;
    logic          tick_reg;

    // Count enabled cycles and strobe on the last one of each period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (en) begin
            if (pre_reg == PRE_LAST) begin
                pre_reg  <= '0;
                tick_reg <= 1'b1;
            end else begin
                pre_reg  <= pre_reg + 1'b1;
                tick_reg <= 1'b0;
            end
        end else begin
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Shared debounce controller: one prescaler and one round-robin pointer
// service N_CH synchronised inputs, each with its own stability counter.
// A channel's clean level flips only after STABLE_TICKS consecutive visits
// in which the synchronised input disagrees with it.
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [N_CH-1:0]                  raw,
    output logic [N_CH-1:0]                  clean,
    output logic [N_CH-1:0]                  rise,
    output logic [N_CH-1:0]                  fall,
    output logic [clog2_min1(N_CH)-1:0]      scan_ch,
    output logic                             tick
);

    localparam int SW = clog2_min1(N_CH);
    localparam int CW = clog2_min1(STABLE_TICKS + 1);
    localparam logic [SW-1:0] PTR_LAST = SW'(N_CH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    if (!params_ok(N_CH, TICK_DIV, STABLE_TICKS)) begin : g_param_err
        $error("debounce_scan_ctrl: need N_CH>=2, TICK_DIV>=1, STABLE_TICKS>=1");
    end

    logic [N_CH-1:0] sync1_reg;
    logic [N_CH-1:0] sync2_reg;
    logic [SW-1:0]   scan_ch_reg;
    logic            tick_int;
    logic            service;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick_int)
    );

    // A visit happens only when the strobe and enable coincide; dropping en
    // on a strobe cycle skips that visit entirely.
    assign service = tick_int & en;

    // Two-flop synchroniser; runs regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Round-robin pointer with explicit wrap so unused codes never occur.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_ch_reg <= '0;
        end else if (service) begin
            scan_ch_reg <= (scan_ch_reg == PTR_LAST) ? '0 : scan_ch_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CW-1:0] cnt_reg;
        logic          clean_reg;
        logic          rise_reg;
        logic          fall_reg;
        logic          hit;

        assign hit = service && (scan_ch_reg == SW'(gi));

        // Per-channel stability counter; a single agreeing visit clears progress.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg   <= '0;
                clean_reg <= 1'b0;
                rise_reg  <= 1'b0;
                fall_reg  <= 1'b0;
            end else begin
                rise_reg <= 1'b0;
                fall_reg <= 1'b0;
                if (hit) begin
                    if (sync2_reg[gi] == clean_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        clean_reg <= ~clean_reg;
                        rise_reg  <= ~clean_reg;
                        fall_reg  <= clean_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
        end

        assign clean[gi] = clean_reg;
        assign rise[gi]  = rise_reg;
        assign fall[gi]  = fall_reg;
    end

    assign scan_ch = scan_ch_reg;
    assign tick    = tick_int;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Self-checking bench for debounce_scan_ctrl with N_CH=4, TICK_DIV=4,
// STABLE_TICKS=3. A behavioural model predicts outputs every cycle; directed
// scenarios add literal expectations.
module tb_debounce_scan_ctrl;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] raw;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [1:0] scan_ch;
    logic       tick;

    always #5 clk = ~clk;

    debounce_scan_ctrl #(
        .N_CH         (N),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .raw     (raw),
        .clean   (clean),
        .rise    (rise),
        .fall    (fall),
        .scan_ch (scan_ch),
        .tick    (tick)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: enabled-cycle count drives the strobe; visits tracked as
    // runs of consecutive disagreeing observations per channel.
    int       m_en_cnt;
    bit       m_tick;
    int       m_ptr;
    int       m_run[4];
    bit [3:0] m_clean, m_rise, m_fall, m_s1, m_s2;
    int       served;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_en_cnt = 0;
        m_tick   = 0;
        m_ptr    = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_clean = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_s1    = '0;
        m_s2    = '0;
        served  = -1;
    endtask

    // Advance one clock: predict from pre-edge state, then compare.
    task automatic step();
        bit [3:0] n_rise, n_fall;
        bit       n_tick;
        int       c;
        n_rise = '0;
        n_fall = '0;
        served = -1;
        if (m_tick && en) begin
            c = m_ptr;
            if (m_s2[c] != m_clean[c]) begin
                m_run[c]++;
                if (m_run[c] == ST) begin
                    m_run[c] = 0;
                    if (m_clean[c]) n_fall[c] = 1'b1;
                    else            n_rise[c] = 1'b1;
                    m_clean[c] = ~m_clean[c];
                end
            end else begin
                m_run[c] = 0;
            end
            m_ptr  = (m_ptr + 1) % N;
            served = c;
        end
        if (en) begin
            m_en_cnt++;
            n_tick = (m_en_cnt % TD) == 0;
        end else begin
            n_tick = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = raw;
        @(posedge clk);
        #1;
        m_tick = n_tick;
        m_rise = n_rise;
        m_fall = n_fall;
        chk("clean", int'(clean), int'(m_clean));
        chk("rise", int'(rise), int'(m_rise));
        chk("fall", int'(fall), int'(m_fall));
        chk("scan_ch", int'(scan_ch), m_ptr);
        chk("tick", int'(tick), int'(m_tick));
    endtask

    task automatic wait_service(input int c);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (served != c && k < 200);
        chk("service_timeout", int'(served == c), 1);
    endtask

    initial begin
        int lat, extra, nvis, rcnt, bad_tick, bad_ptr, bad_clean, held, p, nr, maxpop;
        bit found;
        int rch[4];
        int rcyc[4];

        rst_n = 1'b0;
        en    = 1'b1;
        raw   = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Prescaler and pointer from release.
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("tick_lit", int'(tick), int'((k % 4) == 0));
            chk("scan_lit", int'(scan_ch), ((k - 1) / 4) % 4);
        end

        // Clean press on channel 2.
        raw[2] = 1'b1;
        lat = 0;
        found = 0;
        while (!found && lat < 80) begin
            step();
            lat++;
            if (rise[2]) found = 1;
        end
        chk("press_seen", int'(found), 1);
        chk("press_latency_ok", int'(lat <= 50), 1);
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            extra += int'(rise[2]);
        end
        chk("press_pulse_len", extra, 0);
        chk("press_clean", int'(clean), 4'b0100);

        // Bounce on channel 1.
        wait_service(1);
        raw[1] = 1'b1;
        wait_service(1);
        wait_service(1);
        chk("bounce_v2", int'(clean[1]), 0);
        raw[1] = 1'b0;
        wait_service(1);
        chk("bounce_v3", int'(clean[1]), 0);
        raw[1] = 1'b1;
        wait_service(1);
        wait_service(1);
        chk("bounce_v5", int'(clean[1]), 0);
        wait_service(1);
        chk("bounce_v6", int'(clean[1]), 1);
        chk("bounce_rise", int'(rise), 4'b0010);

        // Release on channel 3.
        raw[3] = 1'b1;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (clean[3]) found = 1;
        end
        chk("ch3_set", int'(found), 1);
        wait_service(3);
        raw[3] = 1'b0;
        nvis = 0;
        rcnt = 0;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (served == 3) nvis++;
            rcnt += int'(rise != 4'b0);
            if (fall[3]) found = 1;
        end
        chk("release_seen", int'(found), 1);
        chk("release_visits", nvis, 3);
        chk("release_no_rise", rcnt, 0);
        step();
        chk("release_pulse_len", int'(fall[3]), 0);
        chk("release_clean", int'(clean), 4'b0110);

        // Enable hold while channel 0 changes.
        en = 1'b0;
        held = m_ptr;
        bad_tick = 0;
        bad_ptr = 0;
        bad_clean = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 5) raw[0] = 1'b1;
            step();
            bad_tick  += int'(tick);
            bad_ptr   += int'(int'(scan_ch) != held);
            bad_clean += int'(clean != 4'b0110);
        end
        chk("hold_tick", bad_tick, 0);
        chk("hold_ptr", bad_ptr, 0);
        chk("hold_clean", bad_clean, 0);
        en = 1'b1;
        nvis = 0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (served == 0) nvis++;
            if (rise[0]) found = 1;
        end
        chk("resume_seen", int'(found), 1);
        chk("resume_visits", nvis, 3);

        // Enable dropped on a strobe cycle: no visit, pointer holds.
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (m_tick) found = 1;
            else step();
        end
        chk("strobe_found", int'(found), 1);
        en = 1'b0;
        p = m_ptr;
        step();
        chk("drop_ptr_hold", int'(scan_ch), p);
        en = 1'b1;

        // Simultaneous change on all channels.
        raw = 4'h0;
        repeat (200) step();
        chk("all_low", int'(clean), 0);
        raw = 4'hF;
        nr = 0;
        maxpop = 0;
        for (int k = 0; k < 120; k++) begin
            step();
            if ($countones(rise) > maxpop) maxpop = $countones(rise);
            if (rise != 4'b0 && nr < 4) begin
                for (int b = 0; b < 4; b++) if (rise[b]) rch[nr] = b;
                rcyc[nr] = k;
                nr++;
            end
        end
        chk("sim_count", nr, 4);
        chk("sim_onehot", maxpop, 1);
        if (nr == 4) begin
            for (int j = 1; j < 4; j++) begin
                chk("sim_spacing", rcyc[j] - rcyc[j-1], 4);
                chk("sim_order", rch[j], (rch[j-1] + 1) % 4);
            end
        end
        chk("sim_clean", int'(clean), 4'hF);

        // Asynchronous reset mid-run.
        repeat (10) step();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_clean", int'(clean), 0);
        chk("rst_rise", int'(rise), 0);
        chk("rst_fall", int'(fall), 0);
        chk("rst_scan", int'(scan_ch), 0);
        chk("rst_tick", int'(tick), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("post_rst_tick", int'(tick), int'((k % 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
